// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared loader state encoding and byte width
// Purpose: common types and constants for the program loader and its packer.
// Contents: state_t (IDLE/LOAD/DONE), BYTE_WIDTH.
package memory_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word packer
// Purpose: collects DATA_WIDTH/8 bytes into one word, byte 0 in the low bits.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   clear            discard any partial word and restart at byte 0
//   byte_valid       byte_data is accepted this cycle
//   byte_data        incoming byte
//   word             packed word including the byte currently presented
//   word_valid       the presented byte completes a word this cycle
import memory_pkg::*;

module byte_packer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int BPW   = DATA_WIDTH / BYTE_WIDTH;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] partial;
  logic                  last;

  assign last       = (count == CNT_W'(BPW - 1));
  assign word_valid = byte_valid && last && !clear;

  // The completing byte is merged combinationally so the word is available
  // in the same cycle it is accepted; the owner registers it.
  always_comb begin
    word = partial;
    for (int j = 0; j < BPW; j++) begin
      if (count == CNT_W'(j)) begin
        word[j*BYTE_WIDTH +: BYTE_WIDTH] = byte_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      partial <= '0;
    end else if (clear) begin
      count   <= '0;
      partial <= '0;
    end else if (byte_valid) begin
      if (last) begin
        count   <= '0;
        partial <= '0;
      end else begin
        count <= count + CNT_W'(1);
        for (int j = 0; j < BPW; j++) begin
          if (count == CNT_W'(j)) begin
            partial[j*BYTE_WIDTH +: BYTE_WIDTH] <= byte_data;
          end
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream to memory word loader
// Purpose: accepts a byte stream after start, packs it into words and writes
//          word_count consecutive words starting at address 0.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   start, word_count     begin a load of word_count words (sampled in IDLE)
//   abort                 cancel the load in progress
//   byte_valid/byte_data  input byte stream, byte_ready is the handshake
//   write_enable/_address/_data  one-cycle memory write strobe and payload
//   busy                  not IDLE
//   done                  one-cycle pulse on completion
//   error                 one-cycle pulse when start is rejected
import memory_pkg::*;

module program_loader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int MEMORY_DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   word_count,
  input  logic                     abort,
  input  logic                     byte_valid,
  input  logic [BYTE_WIDTH-1:0]    byte_data,
  output logic                     byte_ready,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH + 1)'(MEMORY_DEPTH);

  state_t                  state;
  logic [ADDRESS_WIDTH:0]  count_latched;
  logic [ADDRESS_WIDTH:0]  word_index;
  logic [DATA_WIDTH-1:0]   packed_word;
  logic                    word_valid;
  logic                    packer_clear;

  assign byte_ready = (state == LOAD);
  assign busy       = (state != IDLE);

  // Outside LOAD the packer is held empty, so every load starts at byte 0;
  // abort also drops any partial word immediately.
  assign packer_clear = (state != LOAD) || abort;

  byte_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (packer_clear),
    .byte_valid (byte_valid && byte_ready),
    .byte_data  (byte_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count_latched <= '0;
      word_index    <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (word_count > DEPTH) begin
              error <= 1'b1;
            end else begin
              count_latched <= word_count;
              word_index    <= '0;
              state         <= LOAD;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else if (word_valid) begin
            // word_index < count_latched <= MEMORY_DEPTH, so the address
            // always lands inside the memory.
            write_enable  <= 1'b1;
            write_address <= word_index[ADDRESS_WIDTH-1:0];
            write_data    <= packed_word;
            word_index    <= word_index + 1'b1;
            if ((word_index + 1'b1) == count_latched) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Instance a: 16-bit words
  logic        a_start = 1'b0, a_abort = 1'b0, a_byte_valid = 1'b0;
  logic [8:0]  a_word_count = '0;
  logic [7:0]  a_byte_data = '0;
  logic        a_byte_ready, a_write_enable, a_busy, a_done, a_error;
  logic [7:0]  a_write_address;
  logic [15:0] a_write_data;

  // Instance b: 8-bit words
  logic        b_start = 1'b0, b_abort = 1'b0, b_byte_valid = 1'b0;
  logic [8:0]  b_word_count = '0;
  logic [7:0]  b_byte_data = '0;
  logic        b_byte_ready, b_write_enable, b_busy, b_done, b_error;
  logic [7:0]  b_write_address;
  logic [7:0]  b_write_data;

  program_loader #(.ADDRESS_WIDTH(8), .DATA_WIDTH(16), .MEMORY_DEPTH(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(a_start), .word_count(a_word_count),
    .abort(a_abort), .byte_valid(a_byte_valid), .byte_data(a_byte_data),
    .byte_ready(a_byte_ready), .write_enable(a_write_enable),
    .write_address(a_write_address), .write_data(a_write_data),
    .busy(a_busy), .done(a_done), .error(a_error)
  );

  program_loader #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .MEMORY_DEPTH(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(b_start), .word_count(b_word_count),
    .abort(b_abort), .byte_valid(b_byte_valid), .byte_data(b_byte_data),
    .byte_ready(b_byte_ready), .write_enable(b_write_enable),
    .write_address(b_write_address), .write_data(b_write_data),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  int checks = 0;
  int errors = 0;
  int a_wr_n = 0;
  int b_done_n = 0;
  logic [7:0] b_addr_q[$];
  logic [7:0] b_data_q[$];

  always @(negedge clock) begin
    if (a_write_enable) a_wr_n++;
    if (b_write_enable) begin
      b_addr_q.push_back(b_write_address);
      b_data_q.push_back(b_write_data);
    end
    if (b_done) b_done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_two_words(input string tag);
    int wr0;
    wr0 = a_wr_n;
    a_start = 1'b1; a_word_count = 9'd2;
    tick();
    a_start = 1'b0;
    chk({tag, "_busy_load"}, 32'(a_busy), 32'd1);
    chk({tag, "_ready_load"}, 32'(a_byte_ready), 32'd1);
    a_byte_valid = 1'b1; a_byte_data = 8'h34;
    tick();
    chk({tag, "_we_first_byte"}, 32'(a_write_enable), 32'd0);
    a_byte_data = 8'h12;
    tick();
    chk({tag, "_we0"}, 32'(a_write_enable), 32'd1);
    chk({tag, "_addr0"}, 32'(a_write_address), 32'd0);
    chk({tag, "_data0"}, 32'(a_write_data), 32'h1234);
    chk({tag, "_ready_during_write"}, 32'(a_byte_ready), 32'd1);
    chk({tag, "_done_early"}, 32'(a_done), 32'd0);
    a_byte_data = 8'h78;
    tick();
    chk({tag, "_we_pulse_one"}, 32'(a_write_enable), 32'd0);
    chk({tag, "_data_hold"}, 32'(a_write_data), 32'h1234);
    a_byte_data = 8'h56;
    tick();
    chk({tag, "_we1"}, 32'(a_write_enable), 32'd1);
    chk({tag, "_addr1"}, 32'(a_write_address), 32'd1);
    chk({tag, "_data1"}, 32'(a_write_data), 32'h5678);
    chk({tag, "_done"}, 32'(a_done), 32'd1);
    chk({tag, "_busy_done"}, 32'(a_busy), 32'd1);
    chk({tag, "_ready_done"}, 32'(a_byte_ready), 32'd0);
    a_byte_valid = 1'b0;
    tick();
    chk({tag, "_done_pulse_one"}, 32'(a_done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(a_busy), 32'd0);
    chk({tag, "_we_idle"}, 32'(a_write_enable), 32'd0);
    chk({tag, "_write_count"}, 32'(a_wr_n - wr0), 32'd2);
  endtask

  initial begin
    int wr0;
    int sent;
    logic [7:0] exp_byte;

    // Reset state
    #1;
    chk("rst_we", 32'(a_write_enable), 32'd0);
    chk("rst_addr", 32'(a_write_address), 32'd0);
    chk("rst_data", 32'(a_write_data), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_error", 32'(a_error), 32'd0);
    chk("rst_ready", 32'(a_byte_ready), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Two-word load
    run_two_words("load");

    // Oversized word_count is rejected
    wr0 = a_wr_n;
    a_start = 1'b1; a_word_count = 9'd9;
    tick();
    a_start = 1'b0;
    chk("ovf_error", 32'(a_error), 32'd1);
    chk("ovf_busy", 32'(a_busy), 32'd0);
    chk("ovf_we", 32'(a_write_enable), 32'd0);
    tick();
    chk("ovf_error_pulse_one", 32'(a_error), 32'd0);
    chk("ovf_busy_after", 32'(a_busy), 32'd0);

    // word_count = MEMORY_DEPTH is accepted (enters LOAD), then aborted
    a_start = 1'b1; a_word_count = 9'd8;
    tick();
    a_start = 1'b0;
    chk("depth_error", 32'(a_error), 32'd0);
    chk("depth_busy", 32'(a_busy), 32'd1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("depth_abort_idle", 32'(a_busy), 32'd0);

    // Zero-length load
    a_start = 1'b1; a_word_count = 9'd0;
    tick();
    a_start = 1'b0;
    chk("zero_done", 32'(a_done), 32'd1);
    chk("zero_busy", 32'(a_busy), 32'd1);
    chk("zero_we", 32'(a_write_enable), 32'd0);
    tick();
    chk("zero_done_pulse_one", 32'(a_done), 32'd0);
    chk("zero_busy_after", 32'(a_busy), 32'd0);
    chk("zero_no_writes", 32'(a_wr_n - wr0), 32'd0);

    // Abort coinciding with the last byte of a word
    a_start = 1'b1; a_word_count = 9'd2;
    tick();
    a_start = 1'b0;
    a_byte_valid = 1'b1; a_byte_data = 8'h34;
    tick();
    a_byte_data = 8'h12; a_abort = 1'b1;
    tick();
    a_byte_valid = 1'b0; a_abort = 1'b0;
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_ready", 32'(a_byte_ready), 32'd0);
    chk("abort_we", 32'(a_write_enable), 32'd0);
    chk("abort_done", 32'(a_done), 32'd0);
    chk("abort_data_hold", 32'(a_write_data), 32'h5678);
    tick();
    chk("abort_done_after", 32'(a_done), 32'd0);
    chk("abort_no_writes", 32'(a_wr_n - wr0), 32'd0);

    // Reset in the middle of a word
    a_start = 1'b1; a_word_count = 9'd2;
    tick();
    a_start = 1'b0;
    a_byte_valid = 1'b1; a_byte_data = 8'h34;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_we", 32'(a_write_enable), 32'd0);
    chk("midrst_addr", 32'(a_write_address), 32'd0);
    chk("midrst_data", 32'(a_write_data), 32'd0);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_ready", 32'(a_byte_ready), 32'd0);
    chk("midrst_done", 32'(a_done), 32'd0);
    a_byte_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("midrst_no_writes", 32'(a_wr_n - wr0), 32'd0);
    run_two_words("reload");

    // 8-bit words with a randomly gapped stream
    b_start = 1'b1; b_word_count = 9'd8;
    tick();
    b_start = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 200 && sent < 8; cyc++) begin
      b_byte_valid = 1'($urandom_range(0, 1));
      exp_byte = 8'hA0 + 8'(sent * 3);
      b_byte_data = exp_byte;
      tick();
      if (b_byte_valid) sent++;
    end
    b_byte_valid = 1'b0;
    tick();
    tick();
    chk("rand_bytes_sent", 32'(sent), 32'd8);
    chk("rand_write_count", 32'(b_addr_q.size()), 32'd8);
    chk("rand_done_count", 32'(b_done_n), 32'd1);
    chk("rand_busy_after", 32'(b_busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i < b_addr_q.size()) begin
        exp_byte = 8'hA0 + 8'(i * 3);
        chk($sformatf("rand_addr%0d", i), 32'(b_addr_q[i]), 32'(i));
        chk($sformatf("rand_data%0d", i), 32'(b_data_q[i]), 32'(exp_byte));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
